// File: rtl/reg_read_scoreboard.sv
// Register-read scoreboard: int/FP busy vectors gating issue on RAW and WAW hazards.
// issueReady is combinational (same-cycle writeback bypass); busy/count state updates one edge later.
module reg_read_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        issueValid,
  input  logic [4:0]  issueSrcRegAddr1,
  input  logic [4:0]  issueSrcRegAddr2,
  input  logic        issueSrcUse1,
  input  logic        issueSrcUse2,
  input  logic        issueSrcIsFp1,
  input  logic        issueSrcIsFp2,
  input  logic [4:0]  issueDstRegAddr,
  input  logic        issueDstWrite,
  input  logic        issueDstIsFp,
  input  logic        nextStall,
  input  logic        wbValid,
  input  logic [4:0]  wbRegAddr,
  input  logic        wbIsFp,
  input  logic        flush,
  output logic        issueReady,
  output logic [6:0]  pendingCount,
  output logic [31:0] stallCycles
);

  logic [31:0] int_busy, fp_busy;
  logic [31:0] int_busy_nxt, fp_busy_nxt;
  logic [31:0] stall_q;
  logic        src1_haz, src2_haz, waw_haz, fire;
  logic        dst_is_x0;

  function automatic logic busy_bit(input logic [31:0] ib, input logic [31:0] fb,
                                    input logic is_fp, input logic [4:0] addr);
    return is_fp ? fb[addr] : ib[addr];
  endfunction

  function automatic logic wb_match(input logic wb_vld, input logic wb_fp, input logic [4:0] wb_addr,
                                    input logic is_fp, input logic [4:0] addr);
    return wb_vld && (wb_fp == is_fp) && (wb_addr == addr);
  endfunction

  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] cnt;
    cnt = 7'd0;
    for (int i = 0; i < 64; i++) begin
      cnt = cnt + {6'd0, v[i]};
    end
    return cnt;
  endfunction

  always_comb begin
    dst_is_x0 = !issueDstIsFp && (issueDstRegAddr == 5'd0);

    src1_haz = issueSrcUse1
             && busy_bit(int_busy, fp_busy, issueSrcIsFp1, issueSrcRegAddr1)
             && !wb_match(wbValid, wbIsFp, wbRegAddr, issueSrcIsFp1, issueSrcRegAddr1);
    src2_haz = issueSrcUse2
             && busy_bit(int_busy, fp_busy, issueSrcIsFp2, issueSrcRegAddr2)
             && !wb_match(wbValid, wbIsFp, wbRegAddr, issueSrcIsFp2, issueSrcRegAddr2);
    waw_haz  = issueDstWrite && !dst_is_x0
             && busy_bit(int_busy, fp_busy, issueDstIsFp, issueDstRegAddr)
             && !wb_match(wbValid, wbIsFp, wbRegAddr, issueDstIsFp, issueDstRegAddr);

    issueReady = !rst && !nextStall && !flush && !src1_haz && !src2_haz && !waw_haz;
    fire       = issueValid && issueReady;
  end

  // Clear from writeback first, then set from issue, so a new writer wins over a retiring one.
  always_comb begin
    int_busy_nxt = int_busy;
    fp_busy_nxt  = fp_busy;
    if (flush) begin
      int_busy_nxt = 32'd0;
      fp_busy_nxt  = 32'd0;
    end else begin
      if (wbValid) begin
        if (wbIsFp) fp_busy_nxt[wbRegAddr]  = 1'b0;
        else        int_busy_nxt[wbRegAddr] = 1'b0;
      end
      if (fire && issueDstWrite && !dst_is_x0) begin
        if (issueDstIsFp) fp_busy_nxt[issueDstRegAddr]  = 1'b1;
        else              int_busy_nxt[issueDstRegAddr] = 1'b1;
      end
    end
    int_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      int_busy     <= 32'd0;
      fp_busy      <= 32'd0;
      pendingCount <= 7'd0;
      stall_q      <= 32'd0;
    end else begin
      int_busy     <= int_busy_nxt;
      fp_busy      <= fp_busy_nxt;
      pendingCount <= popcount64({int_busy_nxt, fp_busy_nxt});
      if (issueValid && !issueReady && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign stallCycles = stall_q;

endmodule

// File: doc/reg_read_scoreboard.md
REG_READ_SCOREBOARD -- requirements
Module: reg_read_scoreboard

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous active-high reset.
REQ-003 SHALL have: issueValid  in  1  register-read stage holds a valid op.
REQ-004 SHALL have: issueSrcRegAddr1, issueSrcRegAddr2  in  5 each  source register addresses.
REQ-005 SHALL have: issueSrcUse1, issueSrcUse2  in  1 each  op reads that source.
REQ-006 SHALL have: issueSrcIsFp1, issueSrcIsFp2  in  1 each  source in FP file (0 = int file).
REQ-007 SHALL have: issueDstRegAddr  in  5; issueDstWrite  in  1; issueDstIsFp  in  1  destination descriptor.
REQ-008 SHALL have: nextStall  in  1  downstream cannot accept this cycle.
REQ-009 SHALL have: wbValid  in  1; wbRegAddr  in  5; wbIsFp  in  1  writeback retiring a pending destination.
REQ-010 SHALL have: flush  in  1  discard all in-flight ops.
REQ-011 SHALL have: issueReady  out  1  op may advance this cycle (combinational).
REQ-012 SHALL have: pendingCount  out  7  number of set busy bits (0..63).
REQ-013 SHALL have: stallCycles  out  32  saturating count of cycles with issueValid=1 and issueReady=0.

Function
REQ-014 SHALL hold two 32-entry busy vectors, intBusy and fpBusy.
REQ-015 SHALL treat intBusy[0] as constantly 0; int x0 is never set, never a hazard.
REQ-016 Source hazard for source n SHALL be: issueSrcUse n = 1 and busy bit of (issueSrcIsFp n, issueSrcRegAddr n) = 1, excluding a same-cycle wbValid to that same file and address (writeback bypass).
REQ-017 WAW hazard SHALL be: issueDstWrite = 1 and destination busy bit = 1, with the same same-cycle writeback exclusion; int x0 destination is never a WAW hazard.
REQ-018 issueReady SHALL equal not nextStall and not flush and no source hazard and no WAW hazard; it is independent of issueValid.
REQ-019 Issue fire SHALL be issueValid and issueReady.
REQ-020 On fire with issueDstWrite = 1 (excluding int x0), the destination busy bit SHALL be set on the next edge.
REQ-021 On wbValid = 1, the addressed busy bit SHALL be cleared on the next edge; wbValid to a non-busy entry or int x0 is a no-op.
REQ-022 Same-cycle set and clear of one entry: set SHALL win (new writer pending).
REQ-023 flush = 1 SHALL clear all busy bits on the next edge; same-cycle fire and wbValid are ignored.
REQ-024 pendingCount SHALL be registered, equal to the popcount of both vectors after each edge, and reach its new value in the same cycle as the vectors change.
REQ-025 stallCycles SHALL increment by 1 on each cycle with issueValid = 1 and issueReady = 0, saturating at 0xFFFFFFFF; flush does not clear it.
REQ-026 Hazard-to-ready latency SHALL be zero cycles: ready rises in the same cycle as the resolving wbValid.

Reset
REQ-027 While rst = 1, all busy bits, pendingCount, and stallCycles SHALL be 0 on the next edge; rst overrides flush, fire, and wbValid.
REQ-028 While rst = 1, issueReady SHALL be driven 0.

Verification
REQ-029 Reset, then fire int dst x5. Next cycle, an op with src1 = int x5 -> issueReady = 0 and stallCycles increments each cycle. wbValid x5 -> issueReady = 1 in that same cycle, and pendingCount returns 0 one cycle later.
REQ-030 Fire FP dst f5 while int x5 is idle. An op reading int x5 -> issueReady = 1. An op reading fp f5 -> issueReady = 0.
REQ-031 Fire with dst int x0 -> pendingCount stays 0, and a later read of x0 -> issueReady = 1.
REQ-032 x7 busy; same cycle: wbValid x7 and fire new dst x7 -> x7 remains busy, pendingCount stays 1.
REQ-033 Set x1, x2, f3 (pendingCount = 3), then flush = 1 with a fire of dst x4 -> next cycle pendingCount = 0 and all reads ready.
REQ-034 Preload stallCycles to 0xFFFFFFFE via a forced stall, then stall 3 more cycles -> stallCycles = 0xFFFFFFFF. Assert rst -> stallCycles = 0.
